argmax_classifier: RTL and testbench

Final classification stage of the inference pipeline, sitting directly downstream of the softmax unit. It captures the 10-lane softmax probability vector on each `in_valid` pulse and scans it serially, one lane per cycle. It reports the winning class index, its probability, the margin over the runner-up and a low-confidence flag. It also keeps a saturating count of completed classifications and a sticky overrun flag for dropped inputs.

---
 rtl/argmax_classifier.sv | 167 ++++++++++++++++
 tb/tb_argmax_classifier.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_classifier.sv
// Final classification stage: captures a softmax probability vector, scans it one lane per
// cycle and reports top-1 index/value, top-1 minus top-2 margin and a low-confidence flag.
module argmax_classifier #(
    parameter int unsigned       N_CLASSES     = 10,
    parameter int unsigned       DATA_W        = 16,
    parameter logic [DATA_W-1:0] CONF_THRESH   = 16'h4000,
    parameter logic [DATA_W-1:0] MARGIN_THRESH = 16'h0800
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CLASSES*DATA_W-1:0]   probs,
    input  logic                          in_valid,
    output logic                          busy,
    output logic [3:0]                    class_idx,
    output logic [DATA_W-1:0]             class_prob,
    output logic [DATA_W-1:0]             margin,
    output logic                          low_conf,
    output logic                          out_valid,
    output logic [15:0]                   result_count,
    output logic                          overrun
);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StResolve,
        StDone
    } state_e;

    localparam logic [3:0] LastIdx = 4'(N_CLASSES - 1);

    state_e                        state_q, state_d;
    logic [N_CLASSES*DATA_W-1:0]   vec_q, vec_d;
    logic [3:0]                    idx_q, idx_d;
    logic [DATA_W-1:0]             best_q, best_d;
    logic [DATA_W-1:0]             second_q, second_d;
    logic [3:0]                    best_idx_q, best_idx_d;
    logic                          busy_q, busy_d;
    logic [3:0]                    class_idx_q, class_idx_d;
    logic [DATA_W-1:0]             class_prob_q, class_prob_d;
    logic [DATA_W-1:0]             margin_q, margin_d;
    logic                          low_conf_q, low_conf_d;
    logic                          out_valid_q, out_valid_d;
    logic [15:0]                   result_count_q, result_count_d;
    logic                          overrun_q, overrun_d;

    logic [DATA_W-1:0]             lane_v;
    logic [DATA_W-1:0]             margin_v;

    always_comb begin
        state_d        = state_q;
        vec_d          = vec_q;
        idx_d          = idx_q;
        best_d         = best_q;
        second_d       = second_q;
        best_idx_d     = best_idx_q;
        busy_d         = busy_q;
        class_idx_d    = class_idx_q;
        class_prob_d   = class_prob_q;
        margin_d       = margin_q;
        low_conf_d     = low_conf_q;
        out_valid_d    = 1'b0;
        result_count_d = result_count_q;
        overrun_d      = overrun_q;

        lane_v   = vec_q[int'(idx_q) * DATA_W +: DATA_W];
        // best_q >= second_q always holds, so the difference never wraps.
        margin_v = best_q - second_q;

        // A pulse while busy is dropped; the scan in progress carries on untouched.
        if (in_valid && busy_q) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (in_valid) begin
                    vec_d   = probs;
                    idx_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = StScan;
                end else begin
                    state_d = StIdle;
                end
            end

            StScan: begin
                if (idx_q == 4'd0) begin
                    best_d     = lane_v;
                    best_idx_d = 4'd0;
                    second_d   = '0;
                end else if (lane_v > best_q) begin
                    second_d   = best_q;
                    best_d     = lane_v;
                    best_idx_d = idx_q;
                end else if (lane_v > second_q) begin
                    second_d   = lane_v;
                end
                idx_d = idx_q + 4'd1;
                if (idx_q == LastIdx) begin
                    state_d = StResolve;
                end
            end

            StResolve: begin
                class_idx_d  = best_idx_q;
                class_prob_d = best_q;
                margin_d     = margin_v;
                low_conf_d   = (best_q < CONF_THRESH) || (margin_v < MARGIN_THRESH);
                out_valid_d  = 1'b1;
                busy_d       = 1'b0;
                if (result_count_q != 16'hFFFF) begin
                    result_count_d = result_count_q + 16'd1;
                end
                state_d = StDone;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            vec_q          <= '0;
            idx_q          <= '0;
            best_q         <= '0;
            second_q       <= '0;
            best_idx_q     <= '0;
            busy_q         <= 1'b0;
            class_idx_q    <= '0;
            class_prob_q   <= '0;
            margin_q       <= '0;
            low_conf_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            result_count_q <= '0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            vec_q          <= vec_d;
            idx_q          <= idx_d;
            best_q         <= best_d;
            second_q       <= second_d;
            best_idx_q     <= best_idx_d;
            busy_q         <= busy_d;
            class_idx_q    <= class_idx_d;
            class_prob_q   <= class_prob_d;
            margin_q       <= margin_d;
            low_conf_q     <= low_conf_d;
            out_valid_q    <= out_valid_d;
            result_count_q <= result_count_d;
            overrun_q      <= overrun_d;
        end
    end

    assign busy         = busy_q;
    assign class_idx    = class_idx_q;
    assign class_prob   = class_prob_q;
    assign margin       = margin_q;
    assign low_conf     = low_conf_q;
    assign out_valid    = out_valid_q;
    assign result_count = result_count_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Randomised and directed bench for argmax_classifier against a sort-free max/runner-up model.
module tb_argmax_classifier;

    localparam int N = 10;
    localparam int W = 16;
    localparam logic [15:0] ConfThresh   = 16'h4000;
    localparam logic [15:0] MarginThresh = 16'h0800;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] probs;
    logic           in_valid;
    logic           busy;
    logic [3:0]     class_idx;
    logic [W-1:0]   class_prob;
    logic [W-1:0]   margin;
    logic           low_conf;
    logic           out_valid;
    logic [15:0]    result_count;
    logic           overrun;

    int n_checks;
    int n_errors;
    int ov_count;
    int exp_count;

    argmax_classifier dut (
        .clk          (clk),
        .rst          (rst),
        .probs        (probs),
        .in_valid     (in_valid),
        .busy         (busy),
        .class_idx    (class_idx),
        .class_prob   (class_prob),
        .margin       (margin),
        .low_conf     (low_conf),
        .out_valid    (out_valid),
        .result_count (result_count),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counter sees the pre-edge value of out_valid.
    always @(posedge clk) begin
        if (out_valid) ov_count++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Top-1 is the largest lane (lowest index on ties); top-2 is the largest of the rest.
    task automatic model(input logic [N*W-1:0] v, output logic [3:0] e_idx,
                         output logic [15:0] e_prob, output logic [15:0] e_margin,
                         output logic e_low);
        logic [15:0] lanes [N];
        logic [15:0] second;
        int          bi;
        for (int i = 0; i < N; i++) lanes[i] = v[i*W +: W];
        bi = 0;
        for (int i = 1; i < N; i++) if (lanes[i] > lanes[bi]) bi = i;
        second = 16'h0000;
        for (int i = 0; i < N; i++) if (i != bi && lanes[i] > second) second = lanes[i];
        e_idx    = 4'(bi);
        e_prob   = lanes[bi];
        e_margin = lanes[bi] - second;
        e_low    = (lanes[bi] < ConfThresh) || (e_margin < MarginThresh);
    endtask

    task automatic send(input logic [N*W-1:0] v);
        probs    = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [N*W-1:0] v);
        logic [3:0]  e_idx;
        logic [15:0] e_prob;
        logic [15:0] e_margin;
        logic        e_low;
        model(v, e_idx, e_prob, e_margin, e_low);
        check_eq({tag, ".idx"}, 32'(class_idx), 32'(e_idx));
        check_eq({tag, ".prob"}, 32'(class_prob), 32'(e_prob));
        check_eq({tag, ".margin"}, 32'(margin), 32'(e_margin));
        check_eq({tag, ".low_conf"}, 32'(low_conf), 32'(e_low));
    endtask

    // Full transaction from idle: latency, result, count, single-cycle pulse.
    task automatic run_and_check(input string tag, input logic [N*W-1:0] v);
        int lat;
        send(v);
        wait_out(lat);
        check_eq({tag, ".latency"}, 32'(lat), 32'(N + 1));
        check_result(tag, v);
        if (exp_count != 16'hFFFF) exp_count++;
        check_eq({tag, ".count"}, 32'(result_count), 32'(exp_count));
        @(negedge clk);
        check_eq({tag, ".pulse_end"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".busy_end"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [N*W-1:0] flat(input logic [15:0] base, input int pk_a,
                                            input logic [15:0] va, input int pk_b,
                                            input logic [15:0] vb);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = base;
        if (pk_a >= 0) v[pk_a*W +: W] = va;
        if (pk_b >= 0) v[pk_b*W +: W] = vb;
        return v;
    endfunction

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] v;
        int             src;
        int             dst;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) v[i*W +: W] = 16'($urandom_range(0, 16'h8000));
            else v[i*W +: W] = 16'($urandom_range(0, 16'h1000));
        end
        if ($urandom_range(0, 2) == 0) begin
            src = $urandom_range(0, N - 1);
            dst = $urandom_range(0, N - 1);
            v[src*W +: W] = 16'($urandom_range(16'h4000, 16'h7000));
            v[dst*W +: W] = v[src*W +: W];
        end
        return v;
    endfunction

    initial begin
        logic [N*W-1:0] va;
        logic [N*W-1:0] vb;
        logic [N*W-1:0] vc;
        int             lat;
        int             ov_before;

        n_checks  = 0;
        n_errors  = 0;
        ov_count  = 0;
        exp_count = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        probs     = '0;

        repeat (3) @(negedge clk);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.out_valid", 32'(out_valid), 32'd0);
        check_eq("rst.idx", 32'(class_idx), 32'd0);
        check_eq("rst.prob", 32'(class_prob), 32'd0);
        check_eq("rst.margin", 32'(margin), 32'd0);
        check_eq("rst.low_conf", 32'(low_conf), 32'd0);
        check_eq("rst.count", 32'(result_count), 32'd0);
        check_eq("rst.overrun", 32'(overrun), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_and_check("peak7", flat(16'h0100, 7, 16'h7000, -1, 16'h0));
        check_eq("peak7.margin_abs", 32'(margin), 32'h6F00);
        check_eq("peak7.idx_abs", 32'(class_idx), 32'd7);
        run_and_check("tie25", flat(16'h0200, 2, 16'h3000, 5, 16'h3000));
        check_eq("tie25.idx_abs", 32'(class_idx), 32'd2);
        check_eq("tie25.low_abs", 32'(low_conf), 32'd1);
        run_and_check("lowpk9", flat(16'h0400, 9, 16'h3800, -1, 16'h0));
        check_eq("lowpk9.margin_abs", 32'(margin), 32'h3400);
        check_eq("lowpk9.low_abs", 32'(low_conf), 32'd1);
        run_and_check("lane0", flat(16'h1000, 0, 16'h8000, -1, 16'h0));
        run_and_check("allzero", flat(16'h0000, -1, 16'h0, -1, 16'h0));

        for (int t = 0; t < 30; t++) run_and_check("rand", rand_vec());
        check_eq("no_overrun_yet", 32'(overrun), 32'd0);

        // Overrun: second pulse mid-scan is dropped, third pulse in the done cycle is taken.
        va = rand_vec();
        vb = rand_vec();
        vc = rand_vec();
        ov_before = ov_count;
        send(va);
        repeat (3) @(negedge clk);
        send(vb);
        check_eq("ovr.flag", 32'(overrun), 32'd1);
        wait_out(lat);
        check_eq("ovr.latency", 32'(lat), 32'(N + 1 - 4));
        check_result("ovr.first", va);
        exp_count++;
        check_eq("ovr.count1", 32'(result_count), 32'(exp_count));
        send(vc);
        check_eq("ovr.pulse_end", 32'(out_valid), 32'd0);
        check_eq("ovr.busy_again", 32'(busy), 32'd1);
        check_eq("ovr.one_pulse", 32'(ov_count - ov_before), 32'd1);
        wait_out(lat);
        check_eq("ovr.third_latency", 32'(lat), 32'(N + 1));
        check_result("ovr.third", vc);
        exp_count++;
        check_eq("ovr.count2", 32'(result_count), 32'(exp_count));
        @(negedge clk);
        check_eq("ovr.sticky", 32'(overrun), 32'd1);

        // Reset mid-scan aborts the vector.
        send(rand_vec());
        repeat (5) @(negedge clk);
        ov_before = ov_count;
        rst = 1'b0;
        #1;
        check_eq("abort.busy", 32'(busy), 32'd0);
        check_eq("abort.count", 32'(result_count), 32'd0);
        check_eq("abort.overrun", 32'(overrun), 32'd0);
        check_eq("abort.prob", 32'(class_prob), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("abort.no_pulse", 32'(ov_count - ov_before), 32'd0);
        exp_count = 0;
        run_and_check("after_abort", rand_vec());
        check_eq("after_abort.count_abs", 32'(result_count), 32'd1);

        // Saturation: preload just below the ceiling.
        force dut.result_count_q = 16'hFFFE;
        repeat (2) @(negedge clk);
        release dut.result_count_q;
        @(negedge clk);
        check_eq("sat.preload", 32'(result_count), 32'hFFFE);
        exp_count = 16'hFFFE;
        run_and_check("sat.reach", rand_vec());
        run_and_check("sat.hold", rand_vec());
        check_eq("sat.abs", 32'(result_count), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
